// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow-memory port between the I-cache and D-cache
// miss/write-back interfaces. One transaction is granted at a time; every
// completion is followed by a mandatory IDLE cycle before the next grant.
// Per-requester saturating counters record completed transactions.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int RR     = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              I_read,
  input  logic              I_write,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_wdata,
  output logic [DATA_W-1:0] I_rdata,
  output logic              I_ready,
  input  logic              D_read,
  input  logic              D_write,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic [DATA_W-1:0] D_rdata,
  output logic              D_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt_I,
  output logic [CNT_W-1:0]  cnt_D
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic USE_RR = (RR != 0);

  state_t state;
  state_t next_state;
  logic   last_d;      // 1 when the most recent completed grant went to D
  logic   i_pending;
  logic   d_pending;

  assign i_pending = I_read | I_write;
  assign d_pending = D_read | D_write;

  // Read data goes straight to both caches; only the qualified ready matters.
  assign I_rdata = mem_rdata;
  assign D_rdata = mem_rdata;

  // State register, round-robin history and saturating completion counters.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state  <= IDLE;
      last_d <= 1'b0;
      cnt_I  <= '0;
      cnt_D  <= '0;
    end else begin
      state <= next_state;
      if (I_ready) begin
        last_d <= 1'b0;
        if (cnt_I != {CNT_W{1'b1}}) cnt_I <= cnt_I + 1'b1;
      end
      if (D_ready) begin
        last_d <= 1'b1;
        if (cnt_D != {CNT_W{1'b1}}) cnt_D <= cnt_D + 1'b1;
      end
    end
  end

  // Grant decision, memory-port steering and ready qualification.
  always_comb begin
    next_state = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    I_ready    = 1'b0;
    D_ready    = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        // A ready arriving here belongs to nobody and is ignored.
        if (i_pending && d_pending) begin
          // D wins a tie unless round-robin says D went last.
          next_state = (USE_RR && last_d) ? SERVE_I : SERVE_D;
        end else if (i_pending) begin
          next_state = SERVE_I;
        end else if (d_pending) begin
          next_state = SERVE_D;
        end
      end
      SERVE_I: begin
        busy      = 1'b1;
        // Write takes precedence if the requester raises both.
        mem_write = I_write;
        mem_read  = I_read & ~I_write;
        mem_addr  = I_addr;
        mem_wdata = I_wdata;
        // Stay here even if the request drops: the memory is never abandoned.
        if (mem_ready) begin
          I_ready    = 1'b1;
          next_state = IDLE;
        end
      end
      SERVE_D: begin
        busy      = 1'b1;
        mem_write = D_write;
        mem_read  = D_read & ~D_write;
        mem_addr  = D_addr;
        mem_wdata = D_wdata;
        if (mem_ready) begin
          D_ready    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. Two instances share all inputs: a round-robin
// instance with 16-bit counters and a fixed-priority instance with 2-bit
// counters (so counter saturation is reachable in a short run). A select
// signal chooses whose outputs the memory model and checks look at.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic proc_reset;
  logic I_read, I_write, D_read, D_write, mem_ready;
  logic [AW-1:0] I_addr, D_addr;
  logic [DW-1:0] I_wdata, D_wdata, mem_rdata;

  logic [DW-1:0] I_rdata_a, D_rdata_a, mem_wdata_a, I_rdata_b, D_rdata_b, mem_wdata_b;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic I_ready_a, D_ready_a, mem_read_a, mem_write_a, busy_a;
  logic I_ready_b, D_ready_b, mem_read_b, mem_write_b, busy_b;
  logic [15:0] cnt_I_a, cnt_D_a;
  logic [1:0]  cnt_I_b, cnt_D_b;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1), .CNT_W(16)) dut_a (
    .clk(clk), .proc_reset(proc_reset),
    .I_read(I_read), .I_write(I_write), .I_addr(I_addr), .I_wdata(I_wdata),
    .I_rdata(I_rdata_a), .I_ready(I_ready_a),
    .D_read(D_read), .D_write(D_write), .D_addr(D_addr), .D_wdata(D_wdata),
    .D_rdata(D_rdata_a), .D_ready(D_ready_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy_a), .cnt_I(cnt_I_a), .cnt_D(cnt_D_a)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(0), .CNT_W(2)) dut_b (
    .clk(clk), .proc_reset(proc_reset),
    .I_read(I_read), .I_write(I_write), .I_addr(I_addr), .I_wdata(I_wdata),
    .I_rdata(I_rdata_b), .I_ready(I_ready_b),
    .D_read(D_read), .D_write(D_write), .D_addr(D_addr), .D_wdata(D_wdata),
    .D_rdata(D_rdata_b), .D_ready(D_ready_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy_b), .cnt_I(cnt_I_b), .cnt_D(cnt_D_b)
  );

  always #5 clk = ~clk;

  // Output view of the selected instance (0 = round-robin, 1 = fixed priority).
  logic sel = 1'b0;
  wire          s_mem_read  = sel ? mem_read_b  : mem_read_a;
  wire          s_mem_write = sel ? mem_write_b : mem_write_a;
  wire [AW-1:0] s_mem_addr  = sel ? mem_addr_b  : mem_addr_a;
  wire [DW-1:0] s_mem_wdata = sel ? mem_wdata_b : mem_wdata_a;
  wire          s_I_ready   = sel ? I_ready_b   : I_ready_a;
  wire          s_D_ready   = sel ? D_ready_b   : D_ready_a;
  wire [DW-1:0] s_I_rdata   = sel ? I_rdata_b   : I_rdata_a;
  wire [DW-1:0] s_D_rdata   = sel ? D_rdata_b   : D_rdata_a;
  wire          s_busy      = sel ? busy_b      : busy_a;

  typedef struct {
    logic          who;   // 0 = I, 1 = D
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic who, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata);
    txn_t t;
    t.who = who; t.wr = wr; t.addr = addr; t.wdata = wdata;
    exp_q.push_back(t);
  endtask

  // Memory model: waits for a request, checks it against the scoreboard head,
  // answers after lat cycles, then checks the ready pulse and the IDLE gap.
  task automatic mem_txn(input int lat, input logic drop);
    txn_t e;
    int n = 0;
    while (!(s_mem_read || s_mem_write) && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (n < 40 && exp_q.size() > 0) else begin
      bad++;
      $error("FAIL grant_wait observed_cycles=%0d queued=%0d expected_grant", n, exp_q.size());
    end
    if (n >= 40 || exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("busy_serve", 128'(s_busy), 128'(1'b1));
    chk("mem_write", 128'(s_mem_write), 128'(e.wr));
    chk("mem_read", 128'(s_mem_read), 128'(!e.wr));
    chk("mem_addr", 128'(s_mem_addr), 128'(e.addr));
    if (e.wr) chk("mem_wdata", s_mem_wdata, e.wdata);
    if (drop) begin
      if (e.who) begin D_read = 1'b0; D_write = 1'b0; end
      else begin I_read = 1'b0; I_write = 1'b0; end
    end
    repeat (lat) @(negedge clk);
    chk("busy_hold", 128'(s_busy), 128'(1'b1));
    chk("ready_early", 128'({s_I_ready, s_D_ready}), 128'(2'b00));
    mem_rdata = {4{{4'h0, e.addr}}};
    mem_ready = 1'b1;
    #1;
    chk("I_ready", 128'(s_I_ready), 128'(!e.who));
    chk("D_ready", 128'(s_D_ready), 128'(e.who));
    chk("rdata", e.who ? s_D_rdata : s_I_rdata, mem_rdata);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    chk("gap_busy", 128'(s_busy), 128'(1'b0));
    chk("gap_mem_req", 128'({s_mem_read, s_mem_write}), 128'(2'b00));
    $display("txn who=%s wr=%0d addr=%07h lat=%0d", e.who ? "D" : "I", e.wr, e.addr, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    proc_reset = 1'b1;
    I_read = 0; I_write = 0; D_read = 0; D_write = 0; mem_ready = 0;
    I_addr = '0; D_addr = '0; I_wdata = '0; D_wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy_a), 128'(1'b0));
    chk("rst_mem_req", 128'({mem_read_a, mem_write_a}), 128'(2'b00));
    chk("rst_mem_addr", 128'(mem_addr_a), 128'(0));
    chk("rst_cnt_I", 128'(cnt_I_a), 128'(0));
    chk("rst_cnt_D", 128'(cnt_D_a), 128'(0));
    proc_reset = 1'b0;

    // Tie from reset on the round-robin instance: D first, gap, then I.
    @(negedge clk);
    I_read = 1; I_addr = 28'h0000AAA; D_read = 1; D_addr = 28'h0000BBB;
    push(1, 0, 28'h0000BBB, '0);
    push(0, 0, 28'h0000AAA, '0);
    mem_txn(2, 0); D_read = 0;
    mem_txn(2, 0); I_read = 0;
    chk("tie_cnt_I", 128'(cnt_I_a), 128'(1));
    chk("tie_cnt_D", 128'(cnt_D_a), 128'(1));

    // Lone I read, memory answers after 5 cycles; request reaches memory next cycle.
    @(negedge clk);
    I_read = 1; I_addr = 28'h0000123;
    push(0, 0, 28'h0000123, '0);
    @(negedge clk);
    chk("lat_mem_read", 128'(mem_read_a), 128'(1'b1));
    mem_txn(5, 0); I_read = 0;
    chk("lone_cnt_I", 128'(cnt_I_a), 128'(2));
    chk("lone_cnt_D", 128'(cnt_D_a), 128'(1));

    // D write-back then allocate read, request held high through each ready.
    @(negedge clk);
    D_write = 1; D_addr = 28'h0000200; D_wdata = {$urandom, $urandom, $urandom, $urandom};
    push(1, 1, 28'h0000200, D_wdata);
    push(1, 0, 28'h0000300, '0);
    mem_txn(3, 0);
    D_write = 0; D_read = 1; D_addr = 28'h0000300;
    mem_txn(1, 0); D_read = 0;
    chk("wb_cnt_D", 128'(cnt_D_a), 128'(3));

    // Tie after a D grant: round-robin now favours I.
    @(negedge clk);
    I_read = 1; I_addr = 28'h0000400; D_read = 1; D_addr = 28'h0000500;
    push(0, 0, 28'h0000400, '0);
    push(1, 0, 28'h0000500, '0);
    mem_txn(2, 0); I_read = 0;
    mem_txn(2, 0); D_read = 0;
    chk("rr_cnt_I", 128'(cnt_I_a), 128'(3));
    chk("rr_cnt_D", 128'(cnt_D_a), 128'(4));

    // I raises read and write together: write wins.
    @(negedge clk);
    I_read = 1; I_write = 1; I_addr = 28'h0000600; I_wdata = {4{32'hC0FFEE01}};
    push(0, 1, 28'h0000600, I_wdata);
    mem_txn(1, 0); I_read = 0; I_write = 0;

    // D drops its request after grant; arbiter still waits for the memory.
    @(negedge clk);
    D_read = 1; D_addr = 28'h0000700;
    push(1, 0, 28'h0000700, '0);
    mem_txn(4, 1);
    chk("drop_cnt_I", 128'(cnt_I_a), 128'(4));
    chk("drop_cnt_D", 128'(cnt_D_a), 128'(5));

    // Stray mem_ready while IDLE is ignored.
    @(negedge clk);
    mem_ready = 1; #1;
    chk("idle_ready", 128'({I_ready_a, D_ready_a}), 128'(2'b00));
    @(negedge clk);
    mem_ready = 0;
    chk("idle_cnt_I", 128'(cnt_I_a), 128'(4));
    chk("idle_cnt_D", 128'(cnt_D_a), 128'(5));

    // Reset in the middle of a D transaction.
    D_read = 1; D_addr = 28'h0000800;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_read", 128'(mem_read_a), 128'(1'b1));
    #2 proc_reset = 1; #1;
    chk("mid_rst_mem_req", 128'({mem_read_a, mem_write_a}), 128'(2'b00));
    chk("mid_rst_busy", 128'(busy_a), 128'(1'b0));
    chk("mid_rst_cnt", 128'({cnt_I_a, cnt_D_a}), 128'(0));
    mem_ready = 1; #1;
    chk("mid_rst_D_ready", 128'(D_ready_a), 128'(1'b0));
    @(negedge clk);
    mem_ready = 0; D_read = 0; proc_reset = 0;
    $display("txn reset during SERVE_D, no ready forwarded");

    // Fixed-priority instance: I starves while D keeps requesting.
    sel = 1'b1;
    @(negedge clk);
    chk("b_rst_cnt", 128'({cnt_I_b, cnt_D_b}), 128'(0));
    I_read = 1; I_addr = 28'h0000900; D_read = 1; D_addr = 28'h0000A00;
    push(1, 0, 28'h0000A00, '0);
    push(1, 0, 28'h0000A01, '0);
    push(1, 0, 28'h0000A02, '0);
    push(0, 0, 28'h0000900, '0);
    mem_txn(2, 0); D_addr = 28'h0000A01;
    mem_txn(2, 0); D_addr = 28'h0000A02;
    mem_txn(1, 0); D_read = 0;
    mem_txn(2, 0); I_read = 0;
    chk("fp_cnt_D", 128'(cnt_D_b), 128'(3));
    chk("fp_cnt_I", 128'(cnt_I_b), 128'(1));

    // Counter saturation with 2-bit counters: stays at all-ones.
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      I_read = 1; I_addr = 28'h0000B00 + AW'(k);
      push(0, 0, 28'h0000B00 + AW'(k), '0);
      mem_txn(1, 0); I_read = 0;
      chk("sat_cnt_I", 128'(cnt_I_b), 128'((k > 3) ? 3 : k));
    end

    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
